// File: rtl/aes_pkg.sv
// aes_pkg: shared AES definitions for the iterative cipher engines.
//   - default round/key-length parameters
//   - FSM state constants
//   - forward S-box table, xtime / gmul2 / gmul3
//   - round-key slice helper for the packed ExpandedKeys bus
package aes_pkg;

   localparam int NR_DEFAULT = 10;
   localparam int NK_DEFAULT = 4;

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_RUN   = 2'd1;
   localparam logic [1:0] ST_FINAL = 2'd2;

   localparam logic [0:255][7:0] SBOX = {
      128'h637c777bf26b6fc53001672bfed7ab76, 128'hca82c97dfa5947f0add4a2af9ca472c0,
      128'hb7fd9326363ff7cc34a5e5f171d83115, 128'h04c723c31896059a071280e2eb27b275,
      128'h09832c1a1b6e5aa0523bd6b329e32f84, 128'h53d100ed20fcb15b6acbbe394a4c58cf,
      128'hd0efaafb434d338545f9027f503c9fa8, 128'h51a3408f929d38f5bcb6da2110fff3d2,
      128'hcd0c13ec5f974417c4a77e3d645d1973, 128'h60814fdc222a908846eeb814de5e0bdb,
      128'he0323a0a4906245cc2d3ac629195e479, 128'he7c8376d8dd54ea96c56f4ea657aae08,
      128'hba78252e1ca6b4c6e8dd741f4bbd8b8a, 128'h703eb5664803f60e613557b986c11d9e,
      128'he1f8981169d98e949b1e87e9ce5528df, 128'h8ca1890dbfe6426841992d0fb054bb16
   };

   function automatic logic [7:0] sbox(input logic [7:0] b);
      return SBOX[b];
   endfunction

   // Multiply by x in GF(2^8), reducing by the AES polynomial (0x11B).
   function automatic logic [7:0] xtime(input logic [7:0] b);
      return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
   endfunction

   function automatic logic [7:0] gmul2(input logic [7:0] b);
      return xtime(b);
   endfunction

   function automatic logic [7:0] gmul3(input logic [7:0] b);
      return xtime(b) ^ b;
   endfunction

   // MSB index of round key r on a bus of nr+1 keys; key 0 sits in the MSBs.
   function automatic int rk_msb(input int nr, input int r);
      return (nr + 1) * 128 - 1 - r * 128;
   endfunction

endpackage

// File: rtl/aes_cipher_iter_if.sv
// aes_cipher_iter_if: request/response bundle of the iterative cipher.
//   start, enable       caller -> engine handshake
//   input_bytes         plaintext, byte 0 at [127:120]
//   ExpandedKeys        NR+1 round keys, key 0 in the MSBs
//   busy, done, out     engine status and ciphertext
// master = caller side, slave = engine side.
interface aes_cipher_iter_if
   import aes_pkg::*;
#(
   parameter int NR = NR_DEFAULT
);
   logic                    start;
   logic                    enable;
   logic [127:0]            input_bytes;
   logic [128*(NR+1)-1:0]   ExpandedKeys;
   logic                    busy;
   logic                    done;
   logic [127:0]            out;

   modport master (
      output start, enable, input_bytes, ExpandedKeys,
      input  busy, done, out
   );

   modport slave (
      input  start, enable, input_bytes, ExpandedKeys,
      output busy, done, out
   );
endinterface

// File: rtl/aes_enc_round.sv
// aes_enc_round: one combinational AES encryption round.
//   state       current 128-bit state, byte k at [127-8k -: 8]
//   round_key   round key added at the end
//   last        skip MixColumns (final round)
//   next_state  SubBytes -> ShiftRows -> MixColumns? -> AddRoundKey
module aes_enc_round
   import aes_pkg::*;
(
   input  logic [127:0] state,
   input  logic [127:0] round_key,
   input  logic         last,
   output logic [127:0] next_state
);

   logic [7:0] sub [16];
   logic [7:0] shf [16];
   logic [7:0] mix [16];

   // Byte k is row k%4, column k/4; row r is rotated left by r columns.
   for (genvar k = 0; k < 16; k++) begin : g_byte
      assign sub[k] = sbox(state[127-8*k -: 8]);
      assign shf[k] = sub[4*(((k/4) + (k%4)) % 4) + (k%4)];
      assign next_state[127-8*k -: 8] = (last ? shf[k] : mix[k]) ^ round_key[127-8*k -: 8];
   end

   for (genvar c = 0; c < 4; c++) begin : g_col
      logic [7:0] a0, a1, a2, a3;
      assign a0 = shf[4*c];
      assign a1 = shf[4*c+1];
      assign a2 = shf[4*c+2];
      assign a3 = shf[4*c+3];
      assign mix[4*c]   = gmul2(a0) ^ gmul3(a1) ^ a2        ^ a3;
      assign mix[4*c+1] = a0        ^ gmul2(a1) ^ gmul3(a2) ^ a3;
      assign mix[4*c+2] = a0        ^ a1        ^ gmul2(a2) ^ gmul3(a3);
      assign mix[4*c+3] = gmul3(a0) ^ a1        ^ a2        ^ gmul2(a3);
   end

endmodule

// File: rtl/aes_cipher_iter.sv
// aes_cipher_iter: iterative AES encryption, one round per enabled clock.
//   clk, reset   rising-edge clock, synchronous active-high reset
//   bus          aes_cipher_iter_if.slave: start/enable/input_bytes/
//                ExpandedKeys in, busy/done/out back
// Parameters NR (10/12/14) and NK (4/6/8) must satisfy NR == NK+6.
module aes_cipher_iter
   import aes_pkg::*;
#(
   parameter int NR = NR_DEFAULT,
   parameter int NK = NK_DEFAULT
) (
   input logic             clk,
   input logic             reset,
   aes_cipher_iter_if.slave bus
);

   if (NR != NK + 6) begin : g_bad_cfg
      $error("aes_cipher_iter: NR must equal NK+6");
   end

   localparam logic [3:0] LAST_RUN = 4'(NR - 1);

   logic [1:0]   fsm;
   logic [3:0]   round;
   logic [127:0] state;
   logic [127:0] out_q;
   logic         busy_q;
   logic         done_q;

   logic [127:0] rk [NR+1];
   logic [127:0] key_sel;
   logic [127:0] rnd_next;
   logic         last;

   for (genvar r = 0; r <= NR; r++) begin : g_rk
      assign rk[r] = bus.ExpandedKeys[rk_msb(NR, r) -: 128];
   end

   // round already equals NR when FINAL is entered, so one mux serves
   // both the middle rounds and the last one.
   always_comb begin
      key_sel = rk[NR];
      for (int r = 0; r <= NR; r++) begin
         if (round == 4'(r)) key_sel = rk[r];
      end
   end

   assign last = (fsm == ST_FINAL);

   aes_enc_round u_round (
      .state      (state),
      .round_key  (key_sel),
      .last       (last),
      .next_state (rnd_next)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         fsm    <= ST_IDLE;
         round  <= '0;
         state  <= '0;
         out_q  <= '0;
         busy_q <= 1'b0;
         done_q <= 1'b0;
      end else begin
         done_q <= 1'b0;
         case (fsm)
            ST_IDLE: begin
               // enable is deliberately ignored here so a start in the
               // done cycle is always taken.
               if (bus.start) begin
                  state  <= bus.input_bytes ^ rk[0];
                  round  <= 4'd1;
                  busy_q <= 1'b1;
                  fsm    <= ST_RUN;
               end
            end
            ST_RUN: begin
               if (bus.enable) begin
                  state <= rnd_next;
                  round <= round + 4'd1;
                  if (round == LAST_RUN) fsm <= ST_FINAL;
               end
            end
            ST_FINAL: begin
               if (bus.enable) begin
                  out_q  <= rnd_next;
                  busy_q <= 1'b0;
                  done_q <= 1'b1;
                  fsm    <= ST_IDLE;
               end
            end
            default: fsm <= ST_IDLE;
         endcase
      end
   end

   assign bus.busy = busy_q;
   assign bus.done = done_q;
   assign bus.out  = out_q;

endmodule

// File: tb/tb_aes_cipher_iter.sv
// tb_aes_cipher_iter: self-checking bench for aes_cipher_iter.
// Three engines (AES-128/192/256) are built. The AES-128 engine is tracked
// every cycle by a transaction-level model (full ciphertext computed at
// accept, then a countdown of enabled cycles); the others are run directly
// against known-answer vectors.
module tb_aes_cipher_iter;

   logic clk = 1'b0;
   logic reset = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   aes_cipher_iter_if #(.NR(10)) if10 ();
   aes_cipher_iter_if #(.NR(12)) if12 ();
   aes_cipher_iter_if #(.NR(14)) if14 ();

   aes_cipher_iter #(.NR(10), .NK(4)) u10 (.clk(clk), .reset(reset), .bus(if10.slave));
   aes_cipher_iter #(.NR(12), .NK(6)) u12 (.clk(clk), .reset(reset), .bus(if12.slave));
   aes_cipher_iter #(.NR(14), .NK(8)) u14 (.clk(clk), .reset(reset), .bus(if14.slave));

   localparam logic [127:0] PT_B   = 128'h3243f6a8885a308d313198a2e0370734;
   localparam logic [255:0] KEY_B  = {128'h2b7e151628aed2a6abf7158809cf4f3c, 128'h0};
   localparam logic [127:0] CT_B   = 128'h3925841d02dc09fbdc118597196a0b32;
   localparam logic [127:0] PT_C   = 128'h00112233445566778899aabbccddeeff;
   localparam logic [255:0] KEY_C1 = {128'h000102030405060708090a0b0c0d0e0f, 128'h0};
   localparam logic [255:0] KEY_C2 = {192'h000102030405060708090a0b0c0d0e0f1011121314151617, 64'h0};
   localparam logic [255:0] KEY_C3 = 256'h000102030405060708090a0b0c0d0e0f101112131415161718191a1b1c1d1e1f;
   localparam logic [127:0] CT_C1  = 128'h69c4e0d86a7b0430d8cdb78070b4c55a;
   localparam logic [127:0] CT_C2  = 128'hdda97ca4864cdfe06eaf70a0ec0d7191;
   localparam logic [127:0] CT_C3  = 128'h8ea2b7ca516745bfeafc49904b496089;

   // ---------------- reference arithmetic ----------------
   logic [7:0] sb [256];

   function automatic logic [7:0] gmul(input logic [7:0] a, input logic [7:0] b);
      logic [7:0] p, x;
      p = 8'h00;
      x = a;
      for (int i = 0; i < 8; i++) begin
         if (b[i]) p = p ^ x;
         x = {x[6:0], 1'b0} ^ (x[7] ? 8'h1b : 8'h00);
      end
      return p;
   endfunction

   function automatic logic [7:0] rotl8(input logic [7:0] b, input int n);
      return (b << n) | (b >> (8 - n));
   endfunction

   // S-box derived from the GF(2^8) inverse plus the affine map.
   task automatic build_sbox();
      for (int a = 0; a < 256; a++) begin
         logic [7:0] inv;
         inv = 8'h00;
         for (int x = 1; x < 256; x++)
            if (gmul(8'(a), 8'(x)) == 8'h01) inv = 8'(x);
         sb[a] = inv ^ rotl8(inv, 1) ^ rotl8(inv, 2) ^ rotl8(inv, 3) ^ rotl8(inv, 4) ^ 8'h63;
      end
   endtask

   function automatic logic [31:0] subw(input logic [31:0] t);
      return {sb[t[31:24]], sb[t[23:16]], sb[t[15:8]], sb[t[7:0]]};
   endfunction

   // Key schedule, left-aligned on a 15-key bus (key 0 in the MSBs).
   function automatic logic [1919:0] expand(input logic [255:0] key, input int nk);
      logic [31:0]   w [60];
      logic [31:0]   t;
      logic [7:0]    rc;
      logic [1919:0] ek;
      rc = 8'h01;
      for (int i = 0; i < 60; i++) begin
         if (i < nk) w[i] = key[255-32*i -: 32];
         else begin
            t = w[i-1];
            if (i % nk == 0) begin
               t  = subw({t[23:0], t[31:24]}) ^ {rc, 24'h0};
               rc = gmul(rc, 8'h02);
            end else if (nk > 6 && i % nk == 4) t = subw(t);
            w[i] = w[i-nk] ^ t;
         end
         ek[1919-32*i -: 32] = w[i];
      end
      return ek;
   endfunction

   function automatic logic [127:0] aes_model(input logic [127:0] pt, input logic [1919:0] ek, input int nr);
      logic [7:0]   s [16];
      logic [7:0]   t [16];
      logic [7:0]   m [16];
      logic [127:0] v;
      v = pt ^ ek[1919 -: 128];
      for (int r = 1; r <= nr; r++) begin
         for (int k = 0; k < 16; k++) s[k] = sb[v[127-8*k -: 8]];
         for (int k = 0; k < 16; k++) t[k] = s[(k % 4) + 4 * (((k / 4) + (k % 4)) % 4)];
         if (r < nr) begin
            for (int c = 0; c < 4; c++) begin
               m[4*c]   = gmul(t[4*c], 2) ^ gmul(t[4*c+1], 3) ^ t[4*c+2] ^ t[4*c+3];
               m[4*c+1] = t[4*c] ^ gmul(t[4*c+1], 2) ^ gmul(t[4*c+2], 3) ^ t[4*c+3];
               m[4*c+2] = t[4*c] ^ t[4*c+1] ^ gmul(t[4*c+2], 2) ^ gmul(t[4*c+3], 3);
               m[4*c+3] = gmul(t[4*c], 3) ^ t[4*c+1] ^ t[4*c+2] ^ gmul(t[4*c+3], 2);
            end
            for (int k = 0; k < 16; k++) t[k] = m[k];
         end
         for (int k = 0; k < 16; k++) v[127-8*k -: 8] = t[k] ^ ek[1919-128*r-8*k -: 8];
      end
      return v;
   endfunction

   task automatic chk(input string nm, input logic [127:0] act, input logic [127:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // ---------------- cycle model of the AES-128 engine ----------------
   logic         m_busy = 1'b0, m_done = 1'b0;
   logic [127:0] m_out = '0, m_ct = '0;
   int           m_rem = 0;

   always @(posedge clk) begin
      if (reset) begin
         m_busy = 1'b0; m_done = 1'b0; m_out = '0; m_rem = 0;
      end else begin
         m_done = 1'b0;
         if (!m_busy) begin
            if (if10.start) begin
               m_busy = 1'b1;
               m_rem  = 10;
               m_ct   = aes_model(if10.input_bytes, {if10.ExpandedKeys, 512'h0}, 10);
            end
         end else if (if10.enable) begin
            m_rem--;
            if (m_rem == 0) begin
               m_busy = 1'b0; m_done = 1'b1; m_out = m_ct;
            end
         end
      end
   end

   bit   chk_en = 1'b0;
   logic prev_done = 1'b0;

   always @(negedge clk) begin
      if (chk_en) begin
         chk("busy", {127'h0, if10.busy}, {127'h0, m_busy});
         chk("done", {127'h0, if10.done}, {127'h0, m_done});
         chk("out", if10.out, m_out);
         if (if10.done) begin
            chk("done_width", {127'h0, prev_done}, 128'h0);
            chk("busy_with_done", {127'h0, if10.busy}, 128'h0);
         end
         prev_done = if10.done;
      end
   end

   // ---------------- stimulus helpers ----------------
   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   function automatic logic done_of(input int w);
      case (w)
         12:      return if12.done;
         14:      return if14.done;
         default: return if10.done;
      endcase
   endfunction

   task automatic start_op(input int w, input logic [127:0] pt, input logic [1919:0] ek);
      case (w)
         12: begin if12.start = 1'b1; if12.input_bytes = pt; if12.ExpandedKeys = ek[1919 -: 1664]; end
         14: begin if14.start = 1'b1; if14.input_bytes = pt; if14.ExpandedKeys = ek; end
         default: begin if10.start = 1'b1; if10.input_bytes = pt; if10.ExpandedKeys = ek[1919 -: 1408]; end
      endcase
   endtask

   // Counts cycles from the start cycle to the done cycle; -1 on timeout.
   task automatic wait_done(input int w, output int lat);
      tick();
      if10.start = 1'b0; if12.start = 1'b0; if14.start = 1'b0;
      lat = 1;
      while (!done_of(w) && lat < 60) begin
         tick();
         lat++;
      end
      if (!done_of(w)) lat = -1;
   endtask

   // ---------------- main sequence ----------------
   initial begin
      int            lat, n, p, dcnt;
      logic [15:0]   stall;
      logic [1919:0] ek;

      build_sbox();
      if10.start = 0; if10.enable = 1; if10.input_bytes = '0; if10.ExpandedKeys = '0;
      if12.start = 0; if12.enable = 1; if12.input_bytes = '0; if12.ExpandedKeys = '0;
      if14.start = 0; if14.enable = 1; if14.input_bytes = '0; if14.ExpandedKeys = '0;

      tick();
      chk_en = 1'b1;
      tick(); tick();
      reset = 1'b0;
      chk("rst_busy", {127'h0, if10.busy}, 128'h0);
      chk("rst_done", {127'h0, if10.done}, 128'h0);
      chk("rst_out", if10.out, 128'h0);
      chk("rst_out14", if14.out, 128'h0);

      // Known answers pin the model itself.
      chk("model_B",  aes_model(PT_B, expand(KEY_B, 4), 10),  CT_B);
      chk("model_C1", aes_model(PT_C, expand(KEY_C1, 4), 10), CT_C1);
      chk("model_C2", aes_model(PT_C, expand(KEY_C2, 6), 12), CT_C2);
      chk("model_C3", aes_model(PT_C, expand(KEY_C3, 8), 14), CT_C3);

      // C.1 then Appendix B started in the done cycle.
      start_op(10, PT_C, expand(KEY_C1, 4));
      wait_done(10, lat);
      chk("lat_C1", 128'(lat), 128'd11);
      chk("ct_C1", if10.out, CT_C1);
      start_op(10, PT_B, expand(KEY_B, 4));
      wait_done(10, lat);
      chk("lat_B_b2b", 128'(lat), 128'd11);
      chk("ct_B", if10.out, CT_B);
      tick();

      // Three random stall cycles, plus an ignored start while busy.
      stall = '0;
      n = 0;
      while (n < 3) begin
         p = $urandom_range(1, 9);
         if (!stall[p]) begin stall[p] = 1'b1; n++; end
      end
      start_op(10, PT_C, expand(KEY_C1, 4));
      lat = 0;
      do begin
         tick();
         lat++;
         if10.start = 1'b0;
         if (lat == 2) begin if10.start = 1'b1; if10.input_bytes = PT_B; end
         if (lat == 3) chk("out_hold_busy", if10.out, CT_B);
         if10.enable = (lat < 16) ? !stall[lat] : 1'b1;
      end while (!if10.done && lat < 60);
      if10.enable = 1'b1;
      chk("lat_stall", 128'(lat), 128'd14);
      chk("ct_stall", if10.out, CT_C1);
      tick();

      // Reset in cycle c+5 aborts the run silently.
      start_op(10, PT_C, expand(KEY_C1, 4));
      tick();
      if10.start = 1'b0;
      repeat (4) tick();
      reset = 1'b1;
      tick();
      reset = 1'b0;
      chk("abort_busy", {127'h0, if10.busy}, 128'h0);
      chk("abort_out", if10.out, 128'h0);
      dcnt = 0;
      repeat (15) begin
         tick();
         if (if10.done) dcnt++;
      end
      chk("abort_no_done", 128'(dcnt), 128'd0);
      start_op(10, PT_B, expand(KEY_B, 4));
      wait_done(10, lat);
      chk("lat_after_abort", 128'(lat), 128'd11);
      chk("ct_after_abort", if10.out, CT_B);

      // AES-192 / AES-256 builds.
      start_op(12, PT_C, expand(KEY_C2, 6));
      wait_done(12, lat);
      chk("lat_C2", 128'(lat), 128'd13);
      chk("ct_C2", if12.out, CT_C2);
      start_op(14, PT_C, expand(KEY_C3, 8));
      wait_done(14, lat);
      chk("lat_C3", 128'(lat), 128'd15);
      chk("ct_C3", if14.out, CT_C3);

      // Random traffic on the AES-128 engine; keys only change while idle.
      for (int i = 0; i < 600; i++) begin
         if (!m_busy) begin
            ek = expand({$urandom, $urandom, $urandom, $urandom, 128'h0}, 4);
            if10.ExpandedKeys = ek[1919 -: 1408];
            if10.input_bytes  = {$urandom, $urandom, $urandom, $urandom};
            if10.start        = ($urandom_range(0, 2) == 0);
         end else begin
            if10.start = ($urandom_range(0, 7) == 0);
         end
         if10.enable = ($urandom_range(0, 3) != 0);
         tick();
      end
      if10.start = 1'b0;
      if10.enable = 1'b1;
      repeat (20) tick();

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
